// File: rtl/soc_aead_wrapper_if.sv
// Output stream and AEAD core handshake bundle for soc_aead_wrapper.
// The master side is the wrapper; the slave side is the core/sink.
interface soc_aead_wrapper_if #(
  parameter int K  = 128,
  parameter int L  = 16,
  parameter int Y  = 16,
  parameter int OW = 8
);
  logic [OW-1:0]  doutxSO;
  logic           dout_validxSO;
  logic           out_readyxSI;
  logic [K-1:0]   core_key;
  logic [127:0]   core_nonce;
  logic [L-1:0]   core_ad;
  logic [Y-1:0]   core_data;
  logic           core_mode;
  logic           core_startxSO;
  logic           core_donexSI;
  logic [Y-1:0]   core_resultxSI;
  logic [127:0]   core_tagxSI;

  modport master (
    output doutxSO, dout_validxSO, core_key, core_nonce, core_ad, core_data,
           core_mode, core_startxSO,
    input  out_readyxSI, core_donexSI, core_resultxSI, core_tagxSI
  );

  modport slave (
    input  doutxSO, dout_validxSO, core_key, core_nonce, core_ad, core_data,
           core_mode, core_startxSO,
    output out_readyxSI, core_donexSI, core_resultxSI, core_tagxSI
  );
endinterface

// File: rtl/soc_aead_wrapper.sv
// AEAD core wrapper: byte-serial operand loading, single-pulse core launch,
// and a word-serial ready/valid result stream with decrypt tag gating.
module soc_aead_wrapper #(
  parameter int K  = 128,
  parameter int L  = 16,
  parameter int Y  = 16,
  parameter int OW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loadxSI,
  input  logic [31:0] inputxSI,
  input  logic        modexSI,
  input  logic        startxSI,
  input  logic        clearxSI,
  output logic        busyxSO,
  output logic        donexSO,
  output logic        tag_failxSO,
  soc_aead_wrapper_if.master bus
);
  localparam int M1   = (K/8 + 16 > L/8) ? K/8 + 16 : L/8;
  localparam int MAXB = (M1 > Y/8) ? M1 : Y/8;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int NWE  = (Y + 128) / OW;
  localparam int IW   = $clog2(NWE);

  localparam logic [CW-1:0] KB      = CW'(K/8);
  localparam logic [CW-1:0] KTB     = CW'(K/8 + 16);
  localparam logic [CW-1:0] NB      = CW'(16);
  localparam logic [CW-1:0] LB      = CW'(L/8);
  localparam logic [CW-1:0] YB      = CW'(Y/8);
  localparam logic [CW-1:0] LAST_LD = CW'(MAXB - 1);
  localparam logic [IW-1:0] LAST_E  = IW'(NWE - 1);
  localparam logic [IW-1:0] LAST_D  = IW'(Y/OW - 1);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state_q;
  logic [CW-1:0]  cnt_q;
  logic [K-1:0]   key_q;
  logic [127:0]   etag_q;
  logic [127:0]   nonce_q;
  logic [L-1:0]   ad_q;
  logic [Y-1:0]   data_q;
  logic [Y-1:0]   res_q;
  logic [127:0]   ctag_q;
  logic           mode_q;
  logic           start_q;
  logic           fail_q;
  logic [IW-1:0]  idx_q;
  logic [Y+127:0] stream_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      key_q   <= '0;
      etag_q  <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      data_q  <= '0;
      res_q   <= '0;
      ctag_q  <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      fail_q  <= 1'b0;
      idx_q   <= '0;
    end else if (clearxSI) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      key_q   <= '0;
      etag_q  <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      data_q  <= '0;
      res_q   <= '0;
      ctag_q  <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      fail_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          // Lane 0 carries the key first, then the expected tag.
          if (loadxSI) begin
            if (cnt_q < KB) key_q <= K'({key_q, inputxSI[7:0]});
            if (cnt_q >= KB && cnt_q < KTB) etag_q <= {etag_q[119:0], inputxSI[7:0]};
            if (cnt_q < NB) nonce_q <= {nonce_q[119:0], inputxSI[15:8]};
            if (cnt_q < LB) ad_q <= L'({ad_q, inputxSI[23:16]});
            if (cnt_q < YB) data_q <= Y'({data_q, inputxSI[31:24]});
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_LD) state_q <= S_ARMED;
          end
        end
        S_ARMED, S_DONE: begin
          if (startxSI) begin
            mode_q  <= modexSI;
            start_q <= 1'b1;
            fail_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.core_donexSI) begin
            res_q  <= bus.core_resultxSI;
            ctag_q <= bus.core_tagxSI;
            idx_q  <= '0;
            // A failed decrypt skips OUT so no plaintext is ever released.
            if (!mode_q || bus.core_tagxSI == etag_q) begin
              state_q <= S_OUT;
            end else begin
              state_q <= S_DONE;
              fail_q  <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.out_readyxSI) begin
            if (idx_q == (mode_q ? LAST_D : LAST_E)) state_q <= S_DONE;
            else idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Result and tag form one MSB-first stream; decrypt simply stops early.
  assign stream_sh = {res_q, ctag_q} << (32'(idx_q) * OW);

  assign bus.dout_validxSO = (state_q == S_OUT);
  assign bus.doutxSO       = (state_q == S_OUT) ? stream_sh[Y+127 -: OW] : '0;
  assign bus.core_key      = key_q;
  assign bus.core_nonce    = nonce_q;
  assign bus.core_ad       = ad_q;
  assign bus.core_data     = data_q;
  assign bus.core_mode     = mode_q;
  assign bus.core_startxSO = start_q;
  assign busyxSO           = (state_q == S_RUN) || (state_q == S_OUT);
  assign donexSO           = (state_q == S_DONE);
  assign tag_failxSO       = fail_q;
endmodule

// File: tb/tb_soc_aead_wrapper.sv
// Directed bench for soc_aead_wrapper: default byte-wide instance plus a
// 32-bit-word, 64-bit-payload instance sharing the load lanes.
module tb_soc_aead_wrapper;
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] din;
  logic        mode;
  logic        start;
  logic        start2;
  logic        clear;
  logic        busy1, done1, fail1;
  logic        busy2, done2, fail2;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [127:0] tv;
  logic [31:0]  w2 [6];

  soc_aead_wrapper_if #(.K(128), .L(16), .Y(16), .OW(8))  b1 ();
  soc_aead_wrapper_if #(.K(128), .L(16), .Y(64), .OW(32)) b2 ();

  soc_aead_wrapper #(.K(128), .L(16), .Y(16), .OW(8)) dut1 (
    .clk(clk), .rst(rst), .loadxSI(load), .inputxSI(din), .modexSI(mode),
    .startxSI(start), .clearxSI(clear), .busyxSO(busy1), .donexSO(done1),
    .tag_failxSO(fail1), .bus(b1)
  );

  soc_aead_wrapper #(.K(128), .L(16), .Y(64), .OW(32)) dut2 (
    .clk(clk), .rst(rst), .loadxSI(load), .inputxSI(din), .modexSI(mode),
    .startxSI(start2), .clearxSI(clear), .busyxSO(busy2), .donexSO(done2),
    .tag_failxSO(fail2), .bus(b2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    logic [7:0] kt, nn, ad, pt;
    for (int i = 0; i < 32; i++) begin
      kt = (i < 16) ? 8'(i) : 8'((i - 16) * 17);
      nn = (i < 16) ? 8'(16 + i) : 8'h00;
      ad = (i == 0) ? 8'hA1 : (i == 1) ? 8'hB2 : 8'h00;
      pt = (i == 0) ? 8'hC3 : (i == 1) ? 8'hD4 : (i < 8) ? 8'(i - 1) : 8'h00;
      din  = {pt, ad, nn, kt};
      load = 1'b1;
      tick();
    end
    load = 1'b0;
    din  = '0;
  endtask

  initial begin
    tv = 128'h00112233445566778899AABBCCDDEEFF;
    w2[0] = 32'h01234567; w2[1] = 32'h89ABCDEF; w2[2] = 32'h00112233;
    w2[3] = 32'h44556677; w2[4] = 32'h8899AABB; w2[5] = 32'hCCDDEEFF;
    rst = 1'b0; load = 1'b0; din = '0; mode = 1'b0; start = 1'b0;
    start2 = 1'b0; clear = 1'b0;
    b1.out_readyxSI = 1'b0; b1.core_donexSI = 1'b0; b1.core_resultxSI = '0; b1.core_tagxSI = '0;
    b2.out_readyxSI = 1'b0; b2.core_donexSI = 1'b0; b2.core_resultxSI = '0; b2.core_tagxSI = '0;
    #2;
    chk("rst_flags", {busy1, done1, fail1, b1.dout_validxSO, b1.core_startxSO}, 0);
    chk("rst_dout", b1.doutxSO, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Operand load
    load_all();
    chk("ld_key", b1.core_key, 128'h000102030405060708090A0B0C0D0E0F);
    chk("ld_nonce", b1.core_nonce, 128'h101112131415161718191A1B1C1D1E1F);
    chk("ld_ad", b1.core_ad, 16'hA1B2);
    chk("ld_pt", b1.core_data, 16'hC3D4);
    chk("ld_pt2", b2.core_data, 64'hC3D4010203040506);
    chk("armed_flags", {busy1, done1}, 2'b00);
    din = 32'hFFFFFFFF; load = 1'b1;
    tick();
    load = 1'b0; din = '0;
    chk("load_ignored", {b1.core_key, b1.core_data}, {128'h000102030405060708090A0B0C0D0E0F, 16'hC3D4});

    // Encrypt with backpressure on word 1
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("enc_start_pulse", {b1.core_startxSO, busy1, b1.core_mode}, 3'b110);
    b1.core_donexSI = 1'b1; b1.core_resultxSI = 16'h1234; b1.core_tagxSI = tv;
    tick();
    b1.core_donexSI = 1'b0;
    chk("enc_start_once", b1.core_startxSO, 1'b0);
    chk("enc_w0", {b1.dout_validxSO, b1.doutxSO}, 9'h112);
    b1.out_readyxSI = 1'b1;
    tick();
    chk("enc_w1", {b1.dout_validxSO, b1.doutxSO}, 9'h134);
    b1.out_readyxSI = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("enc_hold", {b1.dout_validxSO, b1.doutxSO}, 9'h134);
    end
    b1.out_readyxSI = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) begin
      chk("enc_tag", {b1.dout_validxSO, b1.doutxSO}, {1'b1, tv[127 - 8*j -: 8]});
      tick();
    end
    b1.out_readyxSI = 1'b0;
    chk("enc_done", {done1, busy1, b1.dout_validxSO, b1.core_startxSO, fail1}, 5'b10000);

    // Decrypt with tag mismatch in bit 0
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dmis_run", {b1.core_mode, busy1, b1.dout_validxSO}, 3'b110);
    b1.core_donexSI = 1'b1; b1.core_resultxSI = 16'hFFFF; b1.core_tagxSI = tv ^ 128'h1;
    tick();
    b1.core_donexSI = 1'b0;
    chk("dmis_done", {done1, fail1, b1.dout_validxSO, busy1}, 4'b1100);
    tick();
    chk("dmis_novalid", {b1.dout_validxSO, b1.doutxSO}, 9'h000);

    // Decrypt with matching tag
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dok_failclr", {fail1, busy1}, 2'b01);
    b1.core_donexSI = 1'b1; b1.core_resultxSI = 16'h5A6B; b1.core_tagxSI = tv;
    tick();
    b1.core_donexSI = 1'b0;
    chk("dok_w0", {b1.dout_validxSO, b1.doutxSO}, 9'h15A);
    b1.out_readyxSI = 1'b1;
    tick();
    chk("dok_w1", {b1.dout_validxSO, b1.doutxSO}, 9'h16B);
    tick();
    b1.out_readyxSI = 1'b0;
    chk("dok_done", {done1, b1.dout_validxSO, fail1}, 3'b100);

    // Restart encrypt, then clear after three words
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("re_key", b1.core_key, 128'h000102030405060708090A0B0C0D0E0F);
    b1.core_donexSI = 1'b1; b1.core_resultxSI = 16'h1234; b1.core_tagxSI = tv;
    tick();
    b1.core_donexSI = 1'b0;
    chk("re_w0", {b1.dout_validxSO, b1.doutxSO}, 9'h112);
    b1.out_readyxSI = 1'b1;
    tick(); tick(); tick();
    b1.out_readyxSI = 1'b0;
    chk("re_w3", {b1.dout_validxSO, b1.doutxSO}, 9'h111);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_flags", {b1.dout_validxSO, busy1, done1, fail1, b1.core_mode}, 5'b00000);
    chk("clr_fields", {b1.core_key, b1.core_nonce}, 256'h0);
    chk("clr_data", {b1.core_ad, b1.core_data, b2.core_data}, 96'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_start_ign", {busy1, b1.core_startxSO, done1}, 3'b000);

    // Reload; wide-word instance encrypt
    load_all();
    chk("rl_key", b1.core_key, 128'h000102030405060708090A0B0C0D0E0F);
    mode = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("w32_start", {b2.core_startxSO, busy2, b2.core_data}, {2'b11, 64'hC3D4010203040506});
    b2.core_donexSI = 1'b1; b2.core_resultxSI = 64'h0123456789ABCDEF; b2.core_tagxSI = tv;
    tick();
    b2.core_donexSI = 1'b0;
    b2.out_readyxSI = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("w32_word", {b2.dout_validxSO, b2.doutxSO}, {1'b1, w2[k]});
      tick();
    end
    b2.out_readyxSI = 1'b0;
    chk("w32_done", {done2, b2.dout_validxSO}, 2'b10);

    // Asynchronous reset during RUN
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_run", {busy1, b1.core_startxSO}, 2'b11);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_async", {busy1, b1.core_startxSO, b1.dout_validxSO, done1, fail1}, 5'b00000);
    chk("ar_fields", {b1.core_key, b1.doutxSO}, 136'h0);
    #1;
    rst = 1'b1;
    b1.core_donexSI = 1'b1; b1.core_resultxSI = 16'h1234; b1.core_tagxSI = tv;
    tick();
    b1.core_donexSI = 1'b0;
    chk("ar_late_done", {busy1, done1, b1.dout_validxSO, fail1}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/soc_aead_wrapper.md
SOC_AEAD_WRAPPER -- requirements
Module: soc_aead_wrapper

Interface
REQ-001 SHALL have parameter K, default 128: key length in bits, a multiple of 8.
REQ-002 SHALL have parameter L, default 16: associated-data length in bits, a multiple of 8.
REQ-003 SHALL have parameter Y, default 16: payload length in bits, a multiple of 8 and of OW.
REQ-004 SHALL have parameter OW, default 8: output word width, legal values 8 or 32.
REQ-005 SHALL use one clock; reset is asynchronous and active-low (ports clk and rst).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 loadxSI  input  1  load strobe; one byte per lane per cycle.
REQ-009 inputxSI  input  32  [7:0] key then expected tag; [15:8] nonce; [23:16] AD; [31:24] payload.
REQ-010 modexSI  input  1  0 = encrypt, 1 = decrypt; sampled on start.
REQ-011 startxSI  input  1  start request.
REQ-012 clearxSI  input  1  synchronous return to LOAD with all data zeroed.
REQ-013 out_readyxSI  input  1  sink accepts the output word.
REQ-014 doutxSO / dout_validxSO  output  OW / 1  output word and its valid.
REQ-015 busyxSO / donexSO / tag_failxSO  output  1 each  state flags.
REQ-016 core_key, core_nonce, core_ad, core_data, core_mode  output  K, 128, L, Y, 1  operands to the AEAD core.
REQ-017 core_startxSO  output  1; core_donexSI  input  1; core_resultxSI  input  Y; core_tagxSI  input  128.

Function
REQ-018 SHALL implement states LOAD, ARMED, RUN, OUT, DONE.
REQ-019 LOAD: while loadxSI is high, SHALL shift each lane MSB-first into its field while the byte counter is below that field's byte length (key K/8, tag 16 after the key, nonce 16, AD L/8, payload Y/8), and increment the counter by 1.
REQ-020 SHALL move LOAD->ARMED in the cycle the counter reaches max(K/8+16, 16, L/8, Y/8); counter SHALL saturate there.
REQ-021 loadxSI SHALL be ignored outside LOAD.
REQ-022 In ARMED or DONE, startxSI=1 SHALL latch modexSI into core_mode and enter RUN; startxSI SHALL be ignored in LOAD, RUN and OUT.
REQ-023 core_startxSO SHALL be a single-cycle pulse in the first RUN cycle.
REQ-024 In RUN, core_donexSI=1 SHALL capture core_resultxSI and core_tagxSI into registers and clear the word index.
REQ-025 In the same cycle, encrypt SHALL go to OUT; decrypt SHALL go to OUT when core_tagxSI equals the expected tag, else to DONE with tag_failxSO=1.
REQ-026 OUT SHALL hold dout_validxSO=1 with word n = result[Y-1-n*OW -: OW] for n < Y/OW, then, in encrypt only, tag[127-(n-Y/OW)*OW -: OW].
REQ-027 The word index SHALL advance only on dout_validxSO && out_readyxSI; doutxSO SHALL be stable while valid and not ready.
REQ-028 Word counts: encrypt Y/OW+128/OW, decrypt Y/OW; handshake of the last word SHALL enter DONE.
REQ-029 A decrypt tag mismatch SHALL release no payload word.
REQ-030 busyxSO SHALL be 1 in RUN and OUT; donexSO SHALL be 1 in DONE; tag_failxSO SHALL clear on the next start or clear.
REQ-031 clearxSI SHALL override all other inputs in any state: LOAD, counter, fields, captures and flags zeroed next cycle; in RUN the pending core result SHALL be discarded.
REQ-032 Restart from DONE SHALL reuse the loaded operands and reset the word index.

Reset
REQ-033 rst low SHALL immediately force LOAD and zero all registers and outputs, including doutxSO, dout_validxSO, core_startxSO and every flag.
REQ-034 Reset deasserted mid-RUN SHALL leave a late core_donexSI ignored (state LOAD).

Verification
REQ-035 Defaults, encrypt: load 32 cycles with key 0x00..0F and nonce 0x10..1F, AD=0xA1B2, PT=0xC3D4; start; core returns result 0x1234 and tag T -> core_startxSO pulses once; stream 0x12,0x34 then T bytes MSB-first; 18 words; donexSO=1.
REQ-036 Backpressure: out_readyxSI low 5 cycles on word 1 -> doutxSO held at 0x34, no word lost or repeated.
REQ-037 Decrypt mismatch: expected tag differs from core_tagxSI in bit 0 -> no dout_validxSO, DONE, tag_failxSO=1; decrypt match -> exactly 2 payload words, tag_failxSO=0.
REQ-038 OW=32, Y=64: encrypt -> 2 payload words plus 4 tag words, MSB-first.
REQ-039 clearxSI in OUT after 3 words -> next cycle LOAD, dout_validxSO=0, fields zero; startxSI before reload ignored.
REQ-040 rst pulsed low asynchronously during RUN -> outputs zero before the next clock edge; core_donexSI afterward ignored.
